// File: rtl/vip_sobel_edge_detect_8bit_if.sv
// Pixel-stream bundle for the Sobel edge detector:
// 3x3 window and sync in, edge image, edge map and frame statistics out.
interface vip_sobel_edge_detect_8bit_if #(
    parameter int CNT_W = 20
);
    logic             per_frame_vsync;
    logic             per_frame_href;
    logic             per_frame_clken;
    logic [7:0]       matrix_p11;
    logic [7:0]       matrix_p12;
    logic [7:0]       matrix_p13;
    logic [7:0]       matrix_p21;
    logic [7:0]       matrix_p22;
    logic [7:0]       matrix_p23;
    logic [7:0]       matrix_p31;
    logic [7:0]       matrix_p32;
    logic [7:0]       matrix_p33;
    logic [7:0]       threshold;
    logic             post_frame_vsync;
    logic             post_frame_href;
    logic             post_frame_clken;
    logic [7:0]       post_img_gray;
    logic             post_img_bit;
    logic [CNT_W-1:0] edge_cnt_frame;
    logic             frame_done;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33,
        output threshold,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  post_img_gray, post_img_bit,
        input  edge_cnt_frame, frame_done
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33,
        input  threshold,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output post_img_gray, post_img_bit,
        output edge_cnt_frame, frame_done
    );
endinterface

// File: rtl/vip_sobel_edge_detect_8bit.sv
// 3-stage Sobel |Gx|+|Gy| on a 3x3 window with saturated gray output,
// thresholded edge bit and a per-frame edge-pixel counter.
module vip_sobel_edge_detect_8bit #(
    parameter int CNT_W = 20
) (
    input logic                          clk,
    input logic                          rst,
    vip_sobel_edge_detect_8bit_if.slave  bus
);

    logic [2:0]       vsync_d;
    logic [2:0]       href_d;
    logic [2:0]       clken_d;

    logic [9:0]       gx_p;
    logic [9:0]       gx_n;
    logic [9:0]       gy_p;
    logic [9:0]       gy_n;
    logic [9:0]       gx_abs;
    logic [9:0]       gy_abs;
    logic [10:0]      mag;

    logic [7:0]       gray_q;
    logic             bit_q;

    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_cnt_inc;
    logic [CNT_W-1:0] edge_cnt_q;
    logic             done_q;
    logic             cnt_inc;
    logic             vsync_fall;

    // Sync signals ride a 3-deep shift register to stay aligned with the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d <= '0;
            href_d  <= '0;
            clken_d <= '0;
        end else begin
            vsync_d <= {vsync_d[1:0], bus.per_frame_vsync};
            href_d  <= {href_d[1:0],  bus.per_frame_href};
            clken_d <= {clken_d[1:0], bus.per_frame_clken};
        end
    end

    // Stage 1: weighted column/row sums, each at most 4*255 = 1020.
    always_ff @(posedge clk) begin
        if (rst) begin
            gx_p <= '0;
            gx_n <= '0;
            gy_p <= '0;
            gy_n <= '0;
        end else begin
            gx_p <= {2'b00, bus.matrix_p13} + {1'b0, bus.matrix_p23, 1'b0}
                  + {2'b00, bus.matrix_p33};
            gx_n <= {2'b00, bus.matrix_p11} + {1'b0, bus.matrix_p21, 1'b0}
                  + {2'b00, bus.matrix_p31};
            gy_p <= {2'b00, bus.matrix_p31} + {1'b0, bus.matrix_p32, 1'b0}
                  + {2'b00, bus.matrix_p33};
            gy_n <= {2'b00, bus.matrix_p11} + {1'b0, bus.matrix_p12, 1'b0}
                  + {2'b00, bus.matrix_p13};
        end
    end

    // Stage 2: absolute gradients without going through signed arithmetic.
    always_ff @(posedge clk) begin
        if (rst) begin
            gx_abs <= '0;
            gy_abs <= '0;
        end else begin
            gx_abs <= (gx_p >= gx_n) ? gx_p - gx_n : gx_n - gx_p;
            gy_abs <= (gy_p >= gy_n) ? gy_p - gy_n : gy_n - gy_p;
        end
    end

    assign mag = {1'b0, gx_abs} + {1'b0, gy_abs};

    // Stage 3: saturate to 8 bits and threshold on the full magnitude, blanked outside href.
    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q <= '0;
            bit_q  <= 1'b0;
        end else if (href_d[1]) begin
            gray_q <= (mag > 11'd255) ? 8'hFF : mag[7:0];
            bit_q  <= (mag > {3'b000, bus.threshold});
        end else begin
            gray_q <= '0;
            bit_q  <= 1'b0;
        end
    end

    // Counting works on the values currently on the outputs; the vsync fall is
    // detected on the edge where post_frame_vsync drops, so frame_done lines up with it.
    assign cnt_inc     = href_d[2] & clken_d[2] & bit_q;
    assign vsync_fall  = vsync_d[2] & ~vsync_d[1];
    assign run_cnt_inc = (cnt_inc && run_cnt != '1) ? run_cnt + CNT_W'(1) : run_cnt;

    // Saturating running count, latched and cleared at each frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt    <= '0;
            edge_cnt_q <= '0;
            done_q     <= 1'b0;
        end else if (vsync_fall) begin
            run_cnt    <= '0;
            edge_cnt_q <= run_cnt_inc;
            done_q     <= 1'b1;
        end else begin
            run_cnt    <= run_cnt_inc;
            done_q     <= 1'b0;
        end
    end

    assign bus.post_frame_vsync = vsync_d[2];
    assign bus.post_frame_href  = href_d[2];
    assign bus.post_frame_clken = clken_d[2];
    assign bus.post_img_gray    = gray_q;
    assign bus.post_img_bit     = bit_q;
    assign bus.edge_cnt_frame   = edge_cnt_q;
    assign bus.frame_done       = done_q;

endmodule

// File: tb/tb_vip_sobel_edge_detect_8bit.sv
// Directed bench for the Sobel edge detector: reset, gradients,
// saturation, strict threshold, latency and per-frame edge counting.
module tb_vip_sobel_edge_detect_8bit;

    localparam int IMG_HDISP = 4;
    localparam int IMG_VDISP = 4;
    localparam int CNT_W     = 20;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    vip_sobel_edge_detect_8bit_if #(.CNT_W(CNT_W)) bus ();

    vip_sobel_edge_detect_8bit #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input logic [7:0] a11, a12, a13,
                           input logic [7:0] a21, a22, a23,
                           input logic [7:0] a31, a32, a33);
        bus.matrix_p11 = a11; bus.matrix_p12 = a12; bus.matrix_p13 = a13;
        bus.matrix_p21 = a21; bus.matrix_p22 = a22; bus.matrix_p23 = a23;
        bus.matrix_p31 = a31; bus.matrix_p32 = a32; bus.matrix_p33 = a33;
    endtask

    // Right column 255, left 0: mag 1020, an edge for any threshold.
    task automatic edge_win();
        set_win(8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255);
    endtask

    task automatic zero_win();
        set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    endtask

    // Drive a window with href=clken=1, wait out the latency and check the result.
    task automatic pix_check(input string tag, input logic [7:0] thr,
                             input logic [7:0] exp_gray, input logic exp_bit);
        bus.threshold       = thr;
        bus.per_frame_href  = 1'b1;
        bus.per_frame_clken = 1'b1;
        repeat (3) step();
        check({tag, "_gray"}, 32'(bus.post_img_gray), 32'(exp_gray));
        check({tag, "_bit"},  32'(bus.post_img_bit),  32'(exp_bit));
    endtask

    // IMG_VDISP lines of IMG_HDISP pixels, mask bit set = edge pixel, then vsync falls.
    task automatic run_frame(input string tag, input logic [15:0] mask, input int exp_cnt);
        bus.per_frame_vsync = 1'b1;
        bus.per_frame_href  = 1'b0;
        bus.per_frame_clken = 1'b0;
        zero_win();
        step();
        for (int l = 0; l < IMG_VDISP; l++) begin
            for (int c = 0; c < IMG_HDISP; c++) begin
                bus.per_frame_href  = 1'b1;
                bus.per_frame_clken = 1'b1;
                if (mask[l*IMG_HDISP+c]) edge_win();
                else zero_win();
                step();
            end
            bus.per_frame_href  = 1'b0;
            bus.per_frame_clken = 1'b0;
            zero_win();
            repeat (2) step();
        end
        repeat (2) step();
        bus.per_frame_vsync = 1'b0;
        step();
        check({tag, "_done_t1"}, 32'(bus.frame_done), 32'd0);
        step();
        check({tag, "_done_t2"}, 32'(bus.frame_done), 32'd0);
        check({tag, "_vs_t2"}, 32'(bus.post_frame_vsync), 32'd1);
        step();
        check({tag, "_done_t3"}, 32'(bus.frame_done), 32'd1);
        check({tag, "_vs_t3"}, 32'(bus.post_frame_vsync), 32'd0);
        check({tag, "_cnt"}, 32'(bus.edge_cnt_frame), 32'(exp_cnt));
        step();
        check({tag, "_done_t4"}, 32'(bus.frame_done), 32'd0);
        check({tag, "_cnt_hold"}, 32'(bus.edge_cnt_frame), 32'(exp_cnt));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.per_frame_vsync = 1'b0;
        bus.per_frame_href  = 1'b0;
        bus.per_frame_clken = 1'b0;
        bus.threshold       = 8'd200;
        zero_win();
        repeat (2) step();
        rst = 1'b0;
        check("cnt_before_first_frame", 32'(bus.edge_cnt_frame), 32'd0);

        // Reset mid-frame after counting several edges.
        bus.per_frame_vsync = 1'b1;
        bus.per_frame_href  = 1'b1;
        bus.per_frame_clken = 1'b1;
        edge_win();
        repeat (8) step();
        check("pre_reset_gray", 32'(bus.post_img_gray), 32'd255);
        rst = 1'b1;
        step();
        check("rst_gray",  32'(bus.post_img_gray),    32'd0);
        check("rst_bit",   32'(bus.post_img_bit),     32'd0);
        check("rst_vsync", 32'(bus.post_frame_vsync), 32'd0);
        check("rst_href",  32'(bus.post_frame_href),  32'd0);
        check("rst_clken", 32'(bus.post_frame_clken), 32'd0);
        check("rst_cnt",   32'(bus.edge_cnt_frame),   32'd0);
        check("rst_done",  32'(bus.frame_done),       32'd0);
        rst = 1'b0;
        repeat (2) step();
        bus.per_frame_href  = 1'b0;
        bus.per_frame_clken = 1'b0;
        zero_win();
        repeat (4) step();
        bus.per_frame_vsync = 1'b0;
        repeat (2) step();
        check("rst_frame_done_early", 32'(bus.frame_done), 32'd0);
        step();
        check("rst_frame_done", 32'(bus.frame_done), 32'd1);
        check("rst_frame_cnt", 32'(bus.edge_cnt_frame), 32'd2);
        repeat (3) step();

        // Frame counting: 5 edges, then an empty frame.
        bus.threshold = 8'd200;
        run_frame("frame5", 16'b1000_0100_0010_0011, 5);
        run_frame("frame0", 16'h0000, 0);

        // Flat window.
        set_win(8'd100, 8'd100, 8'd100, 8'd100, 8'd100,
                8'd100, 8'd100, 8'd100, 8'd100);
        pix_check("flat", 8'd0, 8'd0, 1'b0);

        // Strict threshold on Gx = 40.
        set_win(8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10);
        pix_check("gx40_thr40", 8'd40, 8'd40, 1'b0);
        pix_check("gx40_thr39", 8'd39, 8'd40, 1'b1);

        // Negative Gx of the same size.
        set_win(8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0);
        pix_check("gxneg40", 8'd39, 8'd40, 1'b1);

        // Saturation.
        edge_win();
        pix_check("gx1020", 8'd200, 8'd255, 1'b1);
        set_win(8'd0, 8'd128, 8'd128, 8'd128, 8'd128,
                8'd128, 8'd128, 8'd128, 8'd255);
        pix_check("diag510_thr255", 8'd255, 8'd255, 1'b1);
        set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd128, 8'd0, 8'd0, 8'd0);
        pix_check("mag256", 8'd255, 8'd255, 1'b1);
        set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd127, 8'd0, 8'd0, 8'd0);
        pix_check("mag254", 8'd254, 8'd254, 1'b0);

        // Single clken pulse: output valid exactly 3 cycles later.
        bus.threshold       = 8'd39;
        bus.per_frame_href  = 1'b1;
        bus.per_frame_clken = 1'b0;
        zero_win();
        repeat (3) step();
        set_win(8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10);
        bus.per_frame_clken = 1'b1;
        step();
        zero_win();
        bus.per_frame_clken = 1'b0;
        check("pulse_clken_c1", 32'(bus.post_frame_clken), 32'd0);
        step();
        check("pulse_clken_c2", 32'(bus.post_frame_clken), 32'd0);
        step();
        check("pulse_clken_c3", 32'(bus.post_frame_clken), 32'd1);
        check("pulse_gray_c3",  32'(bus.post_img_gray),    32'd40);
        check("pulse_bit_c3",   32'(bus.post_img_bit),     32'd1);
        step();
        check("pulse_clken_c4", 32'(bus.post_frame_clken), 32'd0);
        check("pulse_gray_c4",  32'(bus.post_img_gray),    32'd0);

        // href low blanks the result even with clken high.
        edge_win();
        bus.per_frame_href  = 1'b0;
        bus.per_frame_clken = 1'b1;
        repeat (3) step();
        check("nohref_gray", 32'(bus.post_img_gray),   32'd0);
        check("nohref_bit",  32'(bus.post_img_bit),    32'd0);
        check("nohref_href", 32'(bus.post_frame_href), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
